// File: rtl/rv_mc_mainfsm.sv
// ---------------------------------------------------------------------------
// rv_mc_mainfsm
// Main control FSM for the multicycle RV32I core. A Moore machine steps each
// instruction through fetch, decode, execute, memory and writeback states and
// drives the shared ALU / shared memory datapath. Memory wait states are
// handled through the mem_ready handshake. Illegal opcodes are flagged, and a
// retired-instruction counter is maintained.
//
// Parameters
//   MEM_WAIT_EN : 1 = honour mem_ready, 0 = memory always ready
//   TRAP_HALT   : 1 = ILLEGAL holds until reset, 0 = ILLEGAL returns to FETCH
//   INSTRET_W   : width of the retired-instruction counter (2..64)
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   op         : instruction opcode field, valid from DECODE onwards
//   mem_ready  : memory access completes this cycle
//   PCUpdate   : PC register write enable
//   Branch     : conditional PC update request
//   RegWrite   : register file write enable
//   MemWrite   : data memory write strobe
//   IRWrite    : instruction / OldPC register write enable
//   AdrSrc     : memory address select (0 = PC, 1 = Result)
//   ResultSrc  : 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//   ALUSrcA    : 00 PC, 01 OldPC, 10 rs1
//   ALUSrcB    : 00 rs2, 01 ImmExt, 10 constant 4
//   ALUOp      : 00 add, 01 branch compare, 10 funct-decoded
//   ImmSrc     : 000 I, 001 S, 010 B, 011 J, 100 U (combinational from op)
//   illegal    : high while in ILLEGAL
//   retire     : one-cycle pulse in the last state of each instruction
//   instret    : retired-instruction count, wraps modulo 2^INSTRET_W
// ---------------------------------------------------------------------------
module rv_mc_mainfsm #(
    parameter int MEM_WAIT_EN = 1,
    parameter int TRAP_HALT   = 1,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [6:0]           op,
    input  logic                 mem_ready,
    output logic                 PCUpdate,
    output logic                 Branch,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [2:0]           ImmSrc,
    output logic                 illegal,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_ILLEGAL  = 4'd14
    } state_t;

    state_t state;
    state_t state_next;
    logic   rdy;
    logic   fetch_go;

    assign rdy = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    // The fetch write enables depend on rdy combinationally, so they are also
    // gated by reset_n to keep them low while reset is held.
    assign fetch_go = rdy & reset_n;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Retired-instruction counter; wraps naturally at its width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 1'b1;
        end
    end

    // Immediate format select, decoded straight from the opcode.
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_STORE:          ImmSrc = 3'b001;
            OP_BRANCH:         ImmSrc = 3'b010;
            OP_JAL:            ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:  ImmSrc = 3'b100;
            default:           ImmSrc = 3'b000;
        endcase
    end

    // Next-state and Moore outputs. Every control field defaults to 0 and
    // each state only sets what it uses.
    always_comb begin
        state_next = S_FETCH;
        PCUpdate   = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                IRWrite    = fetch_go;
                PCUpdate   = fetch_go;
                state_next = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_ALUWB;
                    default:           state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = rdy ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                // The strobe stays up through every wait cycle; the store only
                // counts as retired on the cycle memory accepts it.
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                retire     = rdy;
                state_next = rdy ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUOp      = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                Branch     = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // ALUOut already holds the target; ALU forms OldPC+4 for rd.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCUpdate   = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = S_JALR2;
            end
            S_JALR2: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                PCUpdate   = 1'b1;
                state_next = S_ALUWB;
            end
            S_LUI: begin
                ResultSrc  = 2'b11;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal    = 1'b1;
                state_next = (TRAP_HALT != 0) ? S_ILLEGAL : S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_rv_mc_mainfsm.sv
// ---------------------------------------------------------------------------
// tb_rv_mc_mainfsm
// Self-checking bench for rv_mc_mainfsm. Two instances are used: dut_a with
// default parameters, and dut_b with MEM_WAIT_EN=0, TRAP_HALT=0, INSTRET_W=4.
// Each instance has its own reset so one can be idled while the other runs.
// The expected control word for every cycle comes from a per-opcode list of
// steps taken from the instruction timing description.
// ---------------------------------------------------------------------------
module tb_rv_mc_mainfsm;

    localparam logic [15:0] ENABLE_MASK = 16'hF803;

    logic       clk;
    logic       reset_na, reset_nb;
    logic [6:0] op_a, op_b;
    logic       mr_a, mr_b;

    logic        pcu_a, br_a, rw_a, mw_a, irw_a, adr_a, ill_a, ret_a;
    logic [1:0]  rs_a, sa_a, sb_a, aop_a;
    logic [2:0]  imm_a;
    logic [31:0] instret_a;

    logic        pcu_b, br_b, rw_b, mw_b, irw_b, adr_b, ill_b, ret_b;
    logic [1:0]  rs_b, sa_b, sb_b, aop_b;
    logic [2:0]  imm_b;
    logic [3:0]  instret_b;

    logic [15:0] word_a, word_b;

    int tests;
    int fails;
    int cnt [2];

    typedef struct {
        logic [6:0] op;
        int         cycles;
        logic [2:0] imm;
    } vec_t;

    vec_t       vecs [9];
    logic [6:0] legal_ops [9];

    rv_mc_mainfsm dut_a (
        .clk(clk), .reset_n(reset_na), .op(op_a), .mem_ready(mr_a),
        .PCUpdate(pcu_a), .Branch(br_a), .RegWrite(rw_a), .MemWrite(mw_a),
        .IRWrite(irw_a), .AdrSrc(adr_a), .ResultSrc(rs_a), .ALUSrcA(sa_a),
        .ALUSrcB(sb_a), .ALUOp(aop_a), .ImmSrc(imm_a), .illegal(ill_a),
        .retire(ret_a), .instret(instret_a)
    );

    rv_mc_mainfsm #(.MEM_WAIT_EN(0), .TRAP_HALT(0), .INSTRET_W(4)) dut_b (
        .clk(clk), .reset_n(reset_nb), .op(op_b), .mem_ready(mr_b),
        .PCUpdate(pcu_b), .Branch(br_b), .RegWrite(rw_b), .MemWrite(mw_b),
        .IRWrite(irw_b), .AdrSrc(adr_b), .ResultSrc(rs_b), .ALUSrcA(sa_b),
        .ALUSrcB(sb_b), .ALUOp(aop_b), .ImmSrc(imm_b), .illegal(ill_b),
        .retire(ret_b), .instret(instret_b)
    );

    assign word_a = {pcu_a, br_a, rw_a, mw_a, irw_a, adr_a, rs_a, sa_a, sb_a, aop_a, ill_a, ret_a};
    assign word_b = {pcu_b, br_b, rw_b, mw_b, irw_b, adr_b, rs_b, sa_b, sb_b, aop_b, ill_b, ret_b};

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs one control word in the same field order as word_a/word_b.
    function automatic logic [15:0] cw(input logic pcu, input logic br, input logic rw,
                                       input logic mw, input logic irw, input logic adr,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] aop,
                                       input logic ill, input logic ret);
        return {pcu, br, rw, mw, irw, adr, rs, sa, sb, aop, ill, ret};
    endfunction

    // Number of steps an opcode takes when memory is always ready.
    function automatic int n_steps(input logic [6:0] o);
        case (o)
            7'h37, 7'h17, 7'h63:        return 3;
            7'h33, 7'h13, 7'h23, 7'h6F: return 4;
            7'h03, 7'h67:               return 5;
            default:                    return 3;
        endcase
    endfunction

    // Steps that repeat while memory is not ready.
    function automatic logic is_wait(input logic [6:0] o, input int k);
        return (k == 0) || (((o == 7'h03) || (o == 7'h23)) && (k == 3));
    endfunction

    function automatic logic [2:0] exp_imm(input logic [6:0] o);
        case (o)
            7'h23:        return 3'b001;
            7'h63:        return 3'b010;
            7'h6F:        return 3'b011;
            7'h17, 7'h37: return 3'b100;
            default:      return 3'b000;
        endcase
    endfunction

    // Expected control word for step k of opcode o, given effective ready r.
    function automatic logic [15:0] exp_word(input logic [6:0] o, input int k, input logic r);
        logic [15:0] wb;
        logic [15:0] adr_calc;
        logic [15:0] link;
        wb       = cw(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1);
        adr_calc = cw(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0,0);
        link     = cw(1,0,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0,0);
        if (k == 0) return cw(r,0,0,0,r,0,2'b10,2'b00,2'b10,2'b00,0,0);
        if (k == 1) return cw(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,0);
        case (o)
            7'h33: return (k == 2) ? cw(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,0) : wb;
            7'h13: return (k == 2) ? cw(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0,0) : wb;
            7'h03: begin
                if (k == 2) return adr_calc;
                if (k == 3) return cw(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,0);
                return cw(0,0,1,0,0,0,2'b01,2'b00,2'b00,2'b00,0,1);
            end
            7'h23: begin
                if (k == 2) return adr_calc;
                return cw(0,0,0,1,0,1,2'b00,2'b00,2'b00,2'b00,0,r);
            end
            7'h63: return cw(0,1,0,0,0,0,2'b00,2'b10,2'b00,2'b01,0,1);
            7'h6F: return (k == 2) ? link : wb;
            7'h67: begin
                if (k == 2) return adr_calc;
                if (k == 3) return link;
                return wb;
            end
            7'h37: return cw(0,0,1,0,0,0,2'b11,2'b00,2'b00,2'b00,0,0) | 16'h0001;
            7'h17: return wb;
            default: return cw(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0);
        endcase
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] cur_instret(input int sel);
        return (sel != 0) ? {60'd0, instret_b} : {32'd0, instret_a};
    endfunction

    function automatic logic [63:0] model_instret(input int sel);
        return (sel != 0) ? 64'(cnt[1] & 15) : 64'(cnt[0]);
    endfunction

    // Holds the selected instance in reset, checks the reset state, then
    // releases just after a rising edge so the next falling edge is in FETCH.
    task automatic do_reset(input int sel);
        @(negedge clk);
        if (sel != 0) begin reset_nb = 1'b0; mr_b = 1'b1; end
        else          begin reset_na = 1'b0; mr_a = 1'b1; end
        #1;
        check_output("reset enables", ((sel != 0) ? word_b : word_a) & ENABLE_MASK, 64'd0);
        check_output("reset instret", cur_instret(sel), 64'd0);
        cnt[sel] = 0;
        @(posedge clk);
        #1;
        if (sel != 0) reset_nb = 1'b1;
        else          reset_na = 1'b1;
    endtask

    // Runs one instruction cycle by cycle, checking the control word, ImmSrc
    // and instret every cycle. mem_waits forces that many not-ready cycles in
    // the memory access step; rand_rdy randomises ready everywhere else.
    task automatic apply_stimulus(input int sel, input logic [6:0] o, input bit rand_rdy,
                                  input int mem_waits, output int cycles, output int mw_cycles);
        int          k;
        int          waits;
        logic        r;
        logic        eff;
        logic [15:0] ew;
        logic [15:0] got;
        k = 0; cycles = 0; mw_cycles = 0; waits = mem_waits;
        while (k < n_steps(o) && cycles < 60) begin
            @(negedge clk);
            check_output($sformatf("instret op=%02h step=%0d", o, k), cur_instret(sel), model_instret(sel));
            r = 1'b1;
            if (rand_rdy) r = ($urandom_range(0, 3) != 0);
            if (k == 3 && is_wait(o, k)) r = (waits > 0) ? 1'b0 : 1'b1;
            if (k == 3 && is_wait(o, k) && waits > 0) waits--;
            if (sel != 0) begin op_b = o; mr_b = r; end
            else          begin op_a = o; mr_a = r; end
            #1;
            eff = (sel != 0) ? 1'b1 : r;
            ew  = exp_word(o, k, eff);
            got = (sel != 0) ? word_b : word_a;
            check_output($sformatf("ctrl op=%02h step=%0d", o, k), got, ew);
            check_output($sformatf("ImmSrc op=%02h", o), (sel != 0) ? imm_b : imm_a, exp_imm(o));
            if (got[12]) mw_cycles++;
            cycles++;
            if (ew[0]) cnt[sel]++;
            if (!(is_wait(o, k) && !eff)) k++;
        end
        if (cycles >= 60) check_output("cycle budget", 64'(cycles), 64'd0);
    endtask

    initial begin
        int cyc;
        int mwc;
        int idx;
        logic [31:0] held;
        tests = 0; fails = 0; cnt[0] = 0; cnt[1] = 0;
        reset_na = 1'b0; reset_nb = 1'b0;
        op_a = 7'h13; op_b = 7'h13; mr_a = 1'b1; mr_b = 1'b1;

        vecs[0] = '{7'h33, 4, 3'b000};
        vecs[1] = '{7'h13, 4, 3'b000};
        vecs[2] = '{7'h03, 5, 3'b000};
        vecs[3] = '{7'h23, 4, 3'b001};
        vecs[4] = '{7'h63, 3, 3'b010};
        vecs[5] = '{7'h6F, 4, 3'b011};
        vecs[6] = '{7'h67, 5, 3'b000};
        vecs[7] = '{7'h37, 3, 3'b100};
        vecs[8] = '{7'h17, 3, 3'b100};
        for (int i = 0; i < 9; i++) legal_ops[i] = vecs[i].op;

        do_reset(0);

        // One of each opcode with memory always ready.
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(0, vecs[i].op, 1'b0, 0, cyc, mwc);
            check_output($sformatf("cycles op=%02h", vecs[i].op), 64'(cyc), 64'(vecs[i].cycles));
            check_output($sformatf("ImmSrc table op=%02h", vecs[i].op), {61'd0, imm_a}, {61'd0, vecs[i].imm});
        end

        // Load with two wait cycles, store with three.
        apply_stimulus(0, 7'h03, 1'b0, 2, cyc, mwc);
        check_output("load wait cycles", 64'(cyc), 64'd7);
        apply_stimulus(0, 7'h23, 1'b0, 3, cyc, mwc);
        check_output("store wait cycles", 64'(cyc), 64'd7);
        check_output("store MemWrite cycles", 64'(mwc), 64'd4);

        // Random opcode mix with random memory readiness.
        for (int i = 0; i < 80; i++) begin
            idx = $urandom_range(0, 8);
            apply_stimulus(0, legal_ops[idx], 1'b1, $urandom_range(0, 2), cyc, mwc);
        end

        // Reset in the middle of a load: enables drop at once, count clears.
        @(negedge clk);
        op_a = 7'h03; mr_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mr_a = 1'b0;
        #1;
        check_output("abort MEMREAD ctrl", word_a, exp_word(7'h03, 3, 1'b0));
        reset_na = 1'b0;
        #1;
        check_output("abort enables", word_a & ENABLE_MASK, 64'd0);
        check_output("abort instret", cur_instret(0), 64'd0);
        cnt[0] = 0;
        @(posedge clk);
        #1;
        reset_na = 1'b1;
        apply_stimulus(0, 7'h13, 1'b0, 0, cyc, mwc);
        check_output("post-abort cycles", 64'(cyc), 64'd4);

        // Illegal opcode holds in ILLEGAL with no retire.
        apply_stimulus(0, 7'h7F, 1'b0, 0, cyc, mwc);
        held = instret_a;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mr_a = 1'b1;
            #1;
            check_output("illegal hold", word_a, exp_word(7'h7F, 2, 1'b1));
        end
        check_output("illegal instret", {32'd0, instret_a}, {32'd0, held});
        reset_na = 1'b0;

        // No-wait instance: store ignores mem_ready, illegal returns to fetch.
        do_reset(1);
        apply_stimulus(1, 7'h23, 1'b1, 3, cyc, mwc);
        check_output("nowait store cycles", 64'(cyc), 64'd4);
        check_output("nowait store MemWrite", 64'(mwc), 64'd1);
        apply_stimulus(1, 7'h7F, 1'b0, 0, cyc, mwc);
        apply_stimulus(1, 7'h37, 1'b0, 0, cyc, mwc);
        check_output("after illegal cycles", 64'(cyc), 64'd3);

        // Narrow counter wraps after 16 retirements.
        do_reset(1);
        for (int i = 0; i < 16; i++) apply_stimulus(1, 7'h37, 1'b0, 0, cyc, mwc);
        @(negedge clk);
        check_output("instret wrap", {60'd0, instret_b}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
